e_hazard_ctrl: RTL
==================

Name: e_hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage core.
- Generates the E-stage forwarding selects for both ALU source muxes (A and B) and the D-stage branch-comparator forwarding bits.
- Sequences stalls and flushes for branch data hazards and for the multi-cycle multiply/divide unit.
- Sits beside the datapath; drives the selects of the E-stage forwarding muxes and the F/D/E pipeline-register enables and clears.

Parameters:
- MD_LAT, 32, number of stall cycles one multiply/divide occupies in E; legal range 2..64.
- CNT_W, $clog2(MD_LAT+1), width of the busy counter; derived, never overridden.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_addr_rsD, i_addr_rtD  in  5 each  D-stage source register numbers.
- i_addr_rsE, i_addr_rtE  in  5 each  E-stage source register numbers.
- i_addr_wrE, i_addr_wrM, i_addr_wrW  in  5 each  destination register in E, M and W.
- i_con_regwrE, i_con_regwrM, i_con_regwrW  in  1 each  destination write enable per stage.
- i_con_memtoregE, i_con_memtoregM  in  1 each  instruction in that stage is a load.
- i_con_branchD  in  1  D-stage instruction is a branch resolved in D.
- i_con_mdstartE  in  1  E-stage instruction is a multiply/divide.
- o_con_fa  out  2  forwarding select, ALU source A.
- o_con_fb  out  2  forwarding select, ALU source B.
- o_con_fbrA, o_con_fbrB  out  1 each  branch comparator operand takes the M-stage ALU result.
- o_stallF, o_stallD, o_stallE  out  1 each  hold the corresponding pipeline register.
- o_flushE  out  1  clear the D/E register (insert a bubble).
- o_mdbusy  out  1  FSM is in BUSY.

Behaviour:
- Forwarding select encoding (o_con_fa and o_con_fb):
  - 00 = register file.
  - 01 = W-stage writeback result.
  - 10 = M-stage ALU result.
  - 11 = M-stage memory read data.
- Forwarding, per source src in {rsE, rtE}, combinational:
  - src==0 -> 00.
  - Else src==wrM && regwrM -> 11 if memtoregM, else 10.
  - Else src==wrW && regwrW -> 01.
  - Else 00.
  - M always has priority over W.
  - Load-to-use needs no stall: the consumer in E takes memory data via select 11.
- Branch forwarding: o_con_fbrA = branchD && rsD!=0 && rsD==wrM && regwrM && !memtoregM. o_con_fbrB is the same using rtD.
- Branch hazard, combinational: brstall = branchD && (hitE || hitMload).
  - hitE = regwrE && wrE!=0 && wrE in {rsD, rtD}.
  - hitMload = memtoregM && wrM!=0 && wrM in {rsD, rtD}.
  - W-stage producers need no stall; the register file writes first half-cycle.
- MD FSM states: IDLE, BUSY. Counter cnt is CNT_W bits.
  - IDLE, mdstartE=1: mdstall=1; next state BUSY; cnt <= MD_LAT-1.
  - IDLE, mdstartE=0: mdstall=0; stay in IDLE.
  - BUSY, cnt!=0: mdstall=1; cnt decrements.
  - BUSY, cnt==0: mdstall=0; the instruction leaves E at this edge; next state IDLE.
  - mdstartE is ignored while in BUSY.
  - Total stalled cycles = MD_LAT; the MD instruction spends MD_LAT+1 cycles in E.
- Output combination:
  - mdstall=1: stallF=stallD=stallE=1, flushE=0. E is frozen, so mdstall dominates brstall.
  - Else brstall=1: stallF=stallD=1, stallE=0, flushE=1.
  - Else all four are 0.
- Forwarding selects stay live during stalls; they follow the held E operands and the advancing M/W stages.
- Reset (asynchronous, i_rst_n=0):
  - State goes to IDLE and cnt to 0 immediately.
  - o_mdbusy=0.
  - All stall/flush outputs drop to 0 apart from any combinational brstall.
  - Reset in the middle of BUSY abandons the operation; there is no resume.
- Selects have no reset dependence; they are pure functions of the inputs.

Decomposition:
- Shared package hazard_pkg:
  - fwd_sel_t enum: FWD_REG=2'b00, FWD_WB=2'b01, FWD_ALU=2'b10, FWD_MEM=2'b11.
  - md_state_t enum: IDLE, BUSY.
  - Constant REG_ZERO=5'd0.
- One natural sub-module, e_fwd_sel: the per-source priority compare, instantiated twice (rsE, rtE).

Test Plan:
- R-type back-to-back, wrM=5 with regwrM=1, rsE=5, memtoregM=0 -> o_con_fa=10, no stall. Same again with memtoregM=1 -> o_con_fa=11.
- wrM=7 and wrW=7, both writing, rtE=7 -> o_con_fb=10 (M priority). rtE=0 with wrM=0 writing -> o_con_fb=00.
- Branch in D with rsD=9 and regwrE=1, wrE=9 -> stallF=stallD=flushE=1 for exactly 1 cycle; next cycle (producer in M, non-load) o_con_fbrA=1, no stall.
- MD_LAT=4: mdstartE held while stallE=1 -> stall asserted exactly 4 consecutive cycles, o_mdbusy high for 4 cycles, release on the 5th cycle; a following dependent instruction gets o_con_fa=10.
- MD busy coinciding with branch hazard in D -> stallE=1 and flushE=0 throughout; after release, flushE=1 for one cycle if the hazard persists.
- Assert i_rst_n=0 at cnt=2 in BUSY -> o_mdbusy and stalls drop asynchronously; after release the FSM is in IDLE and restarts on a fresh mdstartE.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the E-stage hazard controller.
//   fwd_sel_t  : forwarding mux select encoding for the E-stage ALU sources
//   md_state_t : multiply/divide sequencer states
//   REG_ZERO   : architectural zero register, never a forwarding source
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_ALU = 2'b10,
    FWD_MEM = 2'b11
  } fwd_sel_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/e_fwd_sel.sv
// Per-source forwarding select for one E-stage ALU operand.
// Ports:
//   addr_src           : E-stage source register number
//   addr_wrM, addr_wrW : destination registers of the M and W stages
//   regwrM, regwrW     : destination write enables of the M and W stages
//   memtoregM          : M-stage instruction is a load
//   sel                : 00 regfile, 01 W result, 10 M ALU result, 11 M load data
module e_fwd_sel
  import hazard_pkg::*;
(
  input  logic [4:0] addr_src,
  input  logic [4:0] addr_wrM,
  input  logic [4:0] addr_wrW,
  input  logic       regwrM,
  input  logic       regwrW,
  input  logic       memtoregM,
  output logic [1:0] sel
);

  fwd_sel_t sel_int;

  // M is the younger producer, so it is checked before W.
  always_comb begin
    sel_int = FWD_REG;
    if (addr_src != REG_ZERO) begin
      if (regwrM && (addr_src == addr_wrM)) begin
        if (memtoregM) sel_int = FWD_MEM;
        else           sel_int = FWD_ALU;
      end else if (regwrW && (addr_src == addr_wrW)) begin
        sel_int = FWD_WB;
      end
    end
  end

  assign sel = sel_int;

endmodule

// File: rtl/e_hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage core.
// Produces E-stage ALU forwarding selects, D-stage branch comparator
// forwarding bits, and the F/D/E stall and E flush controls for branch data
// hazards and the multi-cycle multiply/divide unit.
// Ports:
//   i_clk, i_rst_n                 : clock (rising edge), async active-low reset
//   i_addr_rsD/rtD, i_addr_rsE/rtE : D- and E-stage source registers
//   i_addr_wrE/wrM/wrW             : destination registers in E, M, W
//   i_con_regwrE/M/W               : destination write enables
//   i_con_memtoregE/M              : load in E / M
//   i_con_branchD                  : branch resolved in D
//   i_con_mdstartE                 : multiply/divide in E
//   o_con_fa, o_con_fb             : ALU source A/B forwarding selects
//   o_con_fbrA, o_con_fbrB         : branch operand takes M-stage ALU result
//   o_stallF/D/E, o_flushE         : pipeline register hold / D-E clear
//   o_mdbusy                       : multiply/divide sequencer in BUSY
module e_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MD_LAT = 32,
  parameter int CNT_W  = $clog2(MD_LAT + 1)
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [4:0] i_addr_rsD,
  input  logic [4:0] i_addr_rtD,
  input  logic [4:0] i_addr_rsE,
  input  logic [4:0] i_addr_rtE,
  input  logic [4:0] i_addr_wrE,
  input  logic [4:0] i_addr_wrM,
  input  logic [4:0] i_addr_wrW,
  input  logic       i_con_regwrE,
  input  logic       i_con_regwrM,
  input  logic       i_con_regwrW,
  input  logic       i_con_memtoregE,
  input  logic       i_con_memtoregM,
  input  logic       i_con_branchD,
  input  logic       i_con_mdstartE,
  output logic [1:0] o_con_fa,
  output logic [1:0] o_con_fb,
  output logic       o_con_fbrA,
  output logic       o_con_fbrB,
  output logic       o_stallF,
  output logic       o_stallD,
  output logic       o_stallE,
  output logic       o_flushE,
  output logic       o_mdbusy
);

  md_state_t        state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             mdstall;
  logic             brstall;
  logic             hit_e;
  logic             hit_mload;

  // An E-stage load is already covered by its regwrE, so memtoregE adds nothing.
  logic unused_memtoreg_e;
  assign unused_memtoreg_e = i_con_memtoregE;

  e_fwd_sel u_fwd_a (
    .addr_src  (i_addr_rsE),
    .addr_wrM  (i_addr_wrM),
    .addr_wrW  (i_addr_wrW),
    .regwrM    (i_con_regwrM),
    .regwrW    (i_con_regwrW),
    .memtoregM (i_con_memtoregM),
    .sel       (o_con_fa)
  );

  e_fwd_sel u_fwd_b (
    .addr_src  (i_addr_rtE),
    .addr_wrM  (i_addr_wrM),
    .addr_wrW  (i_addr_wrW),
    .regwrM    (i_con_regwrM),
    .regwrW    (i_con_regwrW),
    .memtoregM (i_con_memtoregM),
    .sel       (o_con_fb)
  );

  // Only a non-load M result exists in time for the D-stage comparator.
  assign o_con_fbrA = i_con_branchD && (i_addr_rsD != REG_ZERO) &&
                      (i_addr_rsD == i_addr_wrM) && i_con_regwrM && !i_con_memtoregM;
  assign o_con_fbrB = i_con_branchD && (i_addr_rtD != REG_ZERO) &&
                      (i_addr_rtD == i_addr_wrM) && i_con_regwrM && !i_con_memtoregM;

  // W producers are safe: the register file writes in the first half-cycle.
  assign hit_e     = i_con_regwrE && (i_addr_wrE != REG_ZERO) &&
                     ((i_addr_wrE == i_addr_rsD) || (i_addr_wrE == i_addr_rtD));
  assign hit_mload = i_con_memtoregM && (i_addr_wrM != REG_ZERO) &&
                     ((i_addr_wrM == i_addr_rsD) || (i_addr_wrM == i_addr_rtD));
  assign brstall   = i_con_branchD && (hit_e || hit_mload);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // The starting cycle in IDLE is the first stall; BUSY then adds MD_LAT-1
  // stalls and a final non-stalled cycle in which the instruction leaves E.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    mdstall    = 1'b0;
    case (state)
      IDLE: begin
        if (i_con_mdstartE) begin
          mdstall    = 1'b1;
          state_next = BUSY;
          cnt_next   = CNT_W'(MD_LAT - 1);
        end
      end
      BUSY: begin
        if (cnt != '0) begin
          mdstall  = 1'b1;
          cnt_next = cnt - CNT_W'(1);
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // A frozen E cannot be flushed, so the multiply/divide stall wins.
  assign o_stallF = mdstall || brstall;
  assign o_stallD = mdstall || brstall;
  assign o_stallE = mdstall;
  assign o_flushE = brstall && !mdstall;
  assign o_mdbusy = (state == BUSY);

endmodule
